seven_segment_scan: RTL and testbench
=====================================

# seven_segment_scan

Multiplexed seven-segment display driver that sits directly downstream of the board's 4-bit counter stage. It captures a packed hex value of up to four nibbles, e.g. `cnt` in the low nibble, on a load strobe. It then time-multiplexes the digits onto one shared segment bus with per-digit enables. A fixed blanking interval at the start of every digit slot suppresses ghosting, and leading-zero suppression is optional.

## Interface
- `NDIG`, 4: number of digits, legal 1..4.
- `DIV`, 1000: clock cycles per digit slot, legal ≥ 2.
- `BLANK`, 16: cycles at the start of each slot with all enables inactive, legal 0..DIV-1.
- `ACTIVE_LOW`, 1: 1 inverts `seg` and `an` at the pins (common-anode board); 0 means active-high.
- `LZ_SUPPRESS`, 0: 1 blanks leading zero digits.

Ports:
- `clk`  in  1  single system clock.
- `rst`  in  1  synchronous, active-high reset.
- `val`  in  4*NDIG  packed hex value; nibble i (`val[4i+3:4i]`) is digit i, and digit 0 is rightmost/least significant.
- `load`  in  1  when high at a rising edge, `val` is captured into the shadow register.
- `seg`  out  7  segments {g,f,e,d,c,b,a}, registered.
- `an`  out  NDIG  digit enables, one-hot or all-inactive, registered.

## Operation
- Registers:
  - shadow `sh` (4*NDIG bits).
  - slot prescaler `p` (0..DIV-1).
  - digit index `idx` (0..NDIG-1).
  - current nibble `cur` plus blank flag `bl`.
  - output registers `seg` and `an`.
- Reset, taking priority over everything:
  - `sh` = 0, `p` = DIV-1, `idx` = NDIG-1.
  - `seg` = all segments off, `an` = all inactive; polarity is applied per `ACTIVE_LOW`.
- `load` = 1: `sh` <= `val` on that edge. Otherwise `sh` holds. `load` held high reloads every cycle, which is legal.
- Each cycle with `p` < DIV-1: `p` <= `p`+1.
- Slot boundary, on the edge where `p` == DIV-1:
  - `p` <= 0.
  - `idx` <= (`idx` == NDIG-1) ? 0 : `idx`+1.
  - `cur` <= nibble of the new `idx`, taken from `sh` as it stood before the edge. A `load` on the same edge is not seen until the next slot.
  - `seg` <= decode(`cur`), or all off if `bl` is set.
- Active-high decode, 0..F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
- Leading-zero suppression (`LZ_SUPPRESS` = 1):
  - Digit k > 0 is blanked iff nibbles k..NDIG-1 of `sh` are all zero.
  - Digit 0 is never blanked.
  - Evaluated at the slot boundary together with `cur`.
- Enables: `an` selects bit `idx` exactly in cycles where `p` ≥ BLANK. In cycles where `p` < BLANK, `an` is all inactive.
- `seg` changes only on slot-boundary edges. Because `an` is inactive for BLANK ≥ 1 cycles after each boundary, no stale segment pattern is ever enabled on the new digit.
- NDIG = 1: `idx` stays 0. The slot still repeats and still blanks every DIV cycles.

## Timing
- First rising edge with `rst` = 0 is a slot boundary:
  - `p` = 0, `idx` = 0, `seg` = decode of nibble 0 of `sh`.
  - `an[0]` goes active BLANK cycles later. With BLANK = 0, it is active in that same first cycle.
- Latency from `load` edge to the new value being visible:
  - At least 1 cycle, when the load lands before a boundary.
  - At most DIV+1 cycles for the digit of the next slot.
  - Up to NDIG·DIV+1 cycles until every digit has refreshed.
- Full scan period is NDIG·DIV cycles. Each digit is lit for DIV-BLANK cycles per period.
- `rst` asserted mid-slot: the outputs blank on that edge, and the scan restarts at digit 0 per the rule above. No partial slot survives.
- `val` is ignored without `load`. `seg` and `an` never glitch, because both are registered.

## Test plan
- Reset check, NDIG=4, ACTIVE_LOW=1: hold `rst` 3 cycles -> `seg` = 7'h7F and `an` = 4'hF in every reset cycle.
- Decode sweep, NDIG=1, DIV=4, BLANK=1, ACTIVE_LOW=0: load 0..F, one per slot. Each slot must show the table value, e.g. 5 -> 6D, b -> 7C. `an` = 0 for p=0 and 1 for p=1..3.
- Scan order and timing, NDIG=4, DIV=8, BLANK=2, ACTIVE_LOW=0, load 16'h4321:
  - `an` sequence, from the first boundary after reset, is 0001, 0010, 0100, 1000, then repeats.
  - Each enable lasts 6 cycles.
  - `seg` follows 06, 5B, 4F, 66 in step with the digits.
- Load timing: with the same parameters, load 16'hAAAA on the exact boundary edge entering digit 1. Digit 1 must still show 5B for that slot, and digit 2 must show 77 in the next slot.
- Leading-zero suppression, LZ_SUPPRESS=1:
  - val 16'h0050: digits 3 and 2 blank (`seg` = 00), digit 1 = 6D, digit 0 = 3F.
  - val 16'h0000: only digit 0 is lit, showing 3F.
- Reset mid-scan: assert `rst` while `idx` = 2 and `p` = 5 -> outputs blank on that edge. After release, the first slot is digit 0, showing decode of 0 because `sh` is cleared.

Source files
------------

// File: rtl/seven_segment_scan_if.sv
// Value/strobe in, segment bus and digit enables out, for the scanned
// seven-segment driver.
interface seven_segment_scan_if #(
    parameter int NDIG = 4
);
    logic [4*NDIG-1:0] val;
    logic              load;
    logic [6:0]        seg;
    logic [NDIG-1:0]   an;

    modport master (output val, output load, input seg, input an);
    modport slave  (input val, input load, output seg, output an);
endinterface

// File: rtl/seven_segment_scan.sv
// Time-multiplexed seven-segment driver: shadow-captures a packed hex value and
// scans one digit per DIV-cycle slot, with a blanking prefix at each slot start.
module seven_segment_scan #(
    parameter int NDIG        = 4,
    parameter int DIV         = 1000,
    parameter int BLANK       = 16,
    parameter int ACTIVE_LOW  = 1,
    parameter int LZ_SUPPRESS = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    seven_segment_scan_if.slave  bus
);
    localparam int PW = $clog2(DIV);
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [PW-1:0]   P_LAST  = PW'(DIV - 1);
    localparam logic [IW-1:0]   I_LAST  = IW'(NDIG - 1);
    localparam logic [PW:0]     BLANK_X = (PW + 1)'(BLANK);
    localparam logic [6:0]      SEG_OFF = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [NDIG-1:0] AN_OFF  = (ACTIVE_LOW != 0) ? '1 : '0;

    logic [4*NDIG-1:0] r_sh;
    logic [PW-1:0]     r_p;
    logic [IW-1:0]     r_idx;
    logic [6:0]        r_seg;
    logic [NDIG-1:0]   r_an;

    logic              w_bound;
    logic [PW-1:0]     w_p_nxt;
    logic [IW-1:0]     w_idx_nxt;
    logic [3:0]        w_nib;
    logic              w_bl;
    logic              w_lit;
    logic [NDIG-1:0]   w_sel;

    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
            4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
            4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
            4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
        endcase
        return s;
    endfunction

    function automatic logic [3:0] nib_at(input logic [4*NDIG-1:0] sh, input logic [IW-1:0] k);
        logic [3:0] n;
        n = 4'h0;
        for (int i = 0; i < NDIG; i++)
            if (k == IW'(i)) n = sh[4*i +: 4];
        return n;
    endfunction

    // A digit above 0 is blank when it and every more significant nibble are zero.
    function automatic logic lz_blank(input logic [4*NDIG-1:0] sh, input logic [IW-1:0] k);
        logic b;
        b = (LZ_SUPPRESS != 0) && (k != '0);
        for (int i = 0; i < NDIG; i++)
            if ((IW'(i) >= k) && (sh[4*i +: 4] != 4'h0)) b = 1'b0;
        return b;
    endfunction

    assign w_bound   = (r_p == P_LAST);
    assign w_p_nxt   = w_bound ? '0 : r_p + PW'(1);
    assign w_idx_nxt = !w_bound ? r_idx : ((r_idx == I_LAST) ? '0 : r_idx + IW'(1));
    assign w_nib     = nib_at(r_sh, w_idx_nxt);
    assign w_bl      = lz_blank(r_sh, w_idx_nxt);
    assign w_lit     = ({1'b0, w_p_nxt} >= BLANK_X);
    assign w_sel     = NDIG'(1) << w_idx_nxt;

    // Outputs are stored already in pin polarity so the pins come straight off flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh  <= '0;
            r_p   <= P_LAST;
            r_idx <= I_LAST;
            r_seg <= SEG_OFF;
            r_an  <= AN_OFF;
        end else begin
            if (bus.load) r_sh <= bus.val;
            r_p   <= w_p_nxt;
            r_idx <= w_idx_nxt;
            if (w_bound)
                r_seg <= w_bl ? SEG_OFF : ((ACTIVE_LOW != 0) ? ~decode(w_nib) : decode(w_nib));
            r_an  <= w_lit ? ((ACTIVE_LOW != 0) ? ~w_sel : w_sel) : AN_OFF;
        end
    end

    assign bus.seg = r_seg;
    assign bus.an  = r_an;
endmodule

// File: tb/tb_seven_segment_scan.sv
// Randomized bench: three driver configurations run in lockstep against a
// slot-arithmetic model of the display, plus literal spot checks.
module tb_seven_segment_scan;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] val = 16'h0;

    int tests = 0;
    int fails = 0;
    int k = -1;

    logic [6:0] DEC [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    always #5 clk = ~clk;

    seven_segment_scan_if #(.NDIG(4)) ifa ();
    seven_segment_scan_if #(.NDIG(4)) ifb ();
    seven_segment_scan_if #(.NDIG(1)) ifc ();

    assign ifa.val = val;       assign ifa.load = load;
    assign ifb.val = val;       assign ifb.load = load;
    assign ifc.val = val[3:0];  assign ifc.load = load;

    seven_segment_scan #(.NDIG(4), .DIV(8), .BLANK(2), .ACTIVE_LOW(1), .LZ_SUPPRESS(0))
        dut_a (.clk(clk), .rst(rst), .bus(ifa));
    seven_segment_scan #(.NDIG(4), .DIV(8), .BLANK(2), .ACTIVE_LOW(0), .LZ_SUPPRESS(1))
        dut_b (.clk(clk), .rst(rst), .bus(ifb));
    seven_segment_scan #(.NDIG(1), .DIV(4), .BLANK(1), .ACTIVE_LOW(0), .LZ_SUPPRESS(0))
        dut_c (.clk(clk), .rst(rst), .bus(ifc));

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Expected pins from the slot number n since reset release: digit = slot mod NDIG,
    // showing the shadow value captured when that slot began.
    function automatic logic [6:0] m_seg(input bit inrst, input int n, input int div,
                                         input int ndig, input logic [15:0] snap,
                                         input bit lz, input bit al);
        int d;
        logic [6:0] s;
        d = (n / div) % ndig;
        if (inrst) s = 7'h00;
        else if (lz && d > 0 && (snap >> (4 * d)) == 16'h0) s = 7'h00;
        else s = DEC[snap[4*d +: 4]];
        return al ? ~s : s;
    endfunction

    function automatic logic [3:0] m_an(input bit inrst, input int n, input int div,
                                        input int ndig, input int blank, input bit al);
        logic [3:0] a, mask;
        mask = 4'((1 << ndig) - 1);
        if (inrst || (n % div) < blank) a = 4'h0;
        else a = 4'(1 << ((n / div) % ndig));
        return al ? (~a & mask) : a;
    endfunction

    // Reference model and per-cycle compare.
    initial begin
        int n8, n4;
        bit inrst, r, l;
        logic [15:0] sh, snap8, snap4, v;
        n8 = -1; n4 = -1; inrst = 1'b1; sh = '0; snap8 = '0; snap4 = '0;
        forever begin
            @(posedge clk);
            r = rst; l = load; v = val;
            if (r) begin
                inrst = 1'b1; n8 = -1; n4 = -1; sh = '0;
            end else begin
                inrst = 1'b0;
                n8++; n4++;
                if (n8 % 8 == 0) snap8 = sh;
                if (n4 % 4 == 0) snap4 = {12'h0, sh[3:0]};
                if (l) sh = v;
            end
            #1;
            chk("a_seg", {9'h0, ifa.seg}, {9'h0, m_seg(inrst, n8, 8, 4, snap8, 1'b0, 1'b1)});
            chk("a_an",  {12'h0, ifa.an}, {12'h0, m_an(inrst, n8, 8, 4, 2, 1'b1)});
            chk("b_seg", {9'h0, ifb.seg}, {9'h0, m_seg(inrst, n8, 8, 4, snap8, 1'b1, 1'b0)});
            chk("b_an",  {12'h0, ifb.an}, {12'h0, m_an(inrst, n8, 8, 4, 2, 1'b0)});
            chk("c_seg", {9'h0, ifc.seg}, {9'h0, m_seg(inrst, n4, 4, 1, snap4, 1'b0, 1'b0)});
            chk("c_an",  {15'h0, ifc.an}, {12'h0, m_an(inrst, n4, 4, 1, 1, 1'b0)});
        end
    end

    task automatic cyc(input bit r, input bit l, input logic [15:0] v);
        rst = r; load = l; val = v;
        @(posedge clk);
        #2;
        k = r ? -1 : k + 1;
    endtask

    task automatic run_to(input int t);
        for (int i = 0; i < 200 && k < t; i++) cyc(1'b0, 1'b0, 16'($urandom));
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 16'h0);
            chk("rst_seg", {9'h0, ifa.seg}, 16'h007F);
            chk("rst_an",  {12'h0, ifa.an}, 16'h000F);
        end
        cyc(1'b0, 1'b1, 16'h4321);
        chk("first_b_seg", {9'h0, ifb.seg}, 16'h003F);
        chk("first_b_an",  {12'h0, ifb.an}, 16'h0000);
        chk("first_c_an",  {15'h0, ifc.an}, 16'h0000);
        run_to(8);
        chk("dig1_b_seg", {9'h0, ifb.seg}, 16'h005B);
        chk("dig1_a_seg", {9'h0, ifa.seg}, 16'h0024);
        chk("slot2_c_seg", {9'h0, ifc.seg}, 16'h0006);
        run_to(10);
        chk("dig1_b_an", {12'h0, ifb.an}, 16'h0002);
        chk("dig1_a_an", {12'h0, ifa.an}, 16'h000D);
        run_to(39);
        cyc(1'b0, 1'b1, 16'hAAAA);
        chk("ld_edge_seg", {9'h0, ifb.seg}, 16'h005B);
        run_to(48);
        chk("ld_next_seg", {9'h0, ifb.seg}, 16'h0077);
        cyc(1'b0, 1'b1, 16'h0050);
        run_to(56);  chk("lz_d3", {9'h0, ifb.seg}, 16'h0000);
        run_to(64);  chk("lz_d0", {9'h0, ifb.seg}, 16'h003F);
        run_to(72);  chk("lz_d1", {9'h0, ifb.seg}, 16'h006D);
        run_to(80);  chk("lz_d2", {9'h0, ifb.seg}, 16'h0000);
        cyc(1'b0, 1'b1, 16'h0000);
        run_to(96);  chk("lz0_d0", {9'h0, ifb.seg}, 16'h003F);
        run_to(104); chk("lz0_d1", {9'h0, ifb.seg}, 16'h0000);
        run_to(117);
        cyc(1'b1, 1'b0, 16'h0);
        chk("mid_rst_seg", {9'h0, ifa.seg}, 16'h007F);
        chk("mid_rst_an",  {12'h0, ifa.an}, 16'h000F);
        cyc(1'b0, 1'b0, 16'h0);
        chk("rel_seg", {9'h0, ifb.seg}, 16'h003F);
        run_to(2);
        chk("rel_an", {12'h0, ifb.an}, 16'h0001);
        for (int i = 0; i < 3000; i++)
            cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 7) == 0), 16'($urandom));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
